// File: rtl/jtag_bs_wrapper_pkg.sv
// Shared TAP state encoding, instruction opcodes and DR selection for the
// boundary-scan wrapper.
package jtag_bs_wrapper_pkg;

    // IEEE 1149.1 state encoding, so the state matches the usual debug views.
    typedef enum logic [3:0] {
        TAP_EXIT2_DR   = 4'h0,
        TAP_EXIT1_DR   = 4'h1,
        TAP_SHIFT_DR   = 4'h2,
        TAP_PAUSE_DR   = 4'h3,
        TAP_SELECT_IR  = 4'h4,
        TAP_UPDATE_DR  = 4'h5,
        TAP_CAPTURE_DR = 4'h6,
        TAP_SELECT_DR  = 4'h7,
        TAP_EXIT2_IR   = 4'h8,
        TAP_EXIT1_IR   = 4'h9,
        TAP_SHIFT_IR   = 4'hA,
        TAP_PAUSE_IR   = 4'hB,
        TAP_RTI        = 4'hC,
        TAP_UPDATE_IR  = 4'hD,
        TAP_CAPTURE_IR = 4'hE,
        TAP_TLR        = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_BSR    = 2'd1,
        DR_ID     = 2'd2
    } dr_sel_e;

    // Opcodes are zero-extended to the IR width; BYPASS is all ones.
    localparam logic [31:0] OPC_EXTEST  = 32'd0;
    localparam logic [31:0] OPC_SAMPLE  = 32'd1;
    localparam logic [31:0] OPC_IDCODE  = 32'd2;
    localparam logic [31:0] OPC_INTEST  = 32'd3;
    localparam logic [31:0] IR_CAPTURE  = 32'd1;

    function automatic logic [31:0] op_bypass(input int unsigned ir_w);
        return (ir_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ir_w) - 32'd1);
    endfunction

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        case (s)
            TAP_TLR:        return tms ? TAP_TLR       : TAP_RTI;
            TAP_RTI:        return tms ? TAP_SELECT_DR : TAP_RTI;
            TAP_SELECT_DR:  return tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: return tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:   return tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:   return tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:   return tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:   return tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR:  return tms ? TAP_SELECT_DR : TAP_RTI;
            TAP_SELECT_IR:  return tms ? TAP_TLR       : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: return tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:   return tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:   return tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   return tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   return tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR:  return tms ? TAP_SELECT_DR : TAP_RTI;
            default:        return TAP_TLR;
        endcase
    endfunction

endpackage

// File: rtl/jtag_bs_wrapper_tap_fsm.sv
// 16-state TAP controller; strobes are registered from the next state so they
// are valid for the whole TCLK period of the state they describe.
module jtag_bs_wrapper_tap_fsm
    import jtag_bs_wrapper_pkg::*;
(
    input  logic       tclk_i,
    input  logic       rst_n_i,
    input  logic       tms_i,
    output tap_state_e state_o,
    output logic       shift_ir_o,
    output logic       capture_ir_o,
    output logic       update_ir_o,
    output logic       shift_dr_o,
    output logic       capture_dr_o,
    output logic       update_dr_o,
    output logic       tlr_o
);

    tap_state_e state_q, state_d;
    logic shift_ir_q, capture_ir_q, update_ir_q;
    logic shift_dr_q, capture_dr_q, update_dr_q, tlr_q;

    always_comb state_d = tap_next(state_q, tms_i);

    always_ff @(posedge tclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= TAP_TLR;
            shift_ir_q   <= 1'b0;
            capture_ir_q <= 1'b0;
            update_ir_q  <= 1'b0;
            shift_dr_q   <= 1'b0;
            capture_dr_q <= 1'b0;
            update_dr_q  <= 1'b0;
            tlr_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_ir_q   <= (state_d == TAP_SHIFT_IR);
            capture_ir_q <= (state_d == TAP_CAPTURE_IR);
            update_ir_q  <= (state_d == TAP_UPDATE_IR);
            shift_dr_q   <= (state_d == TAP_SHIFT_DR);
            capture_dr_q <= (state_d == TAP_CAPTURE_DR);
            update_dr_q  <= (state_d == TAP_UPDATE_DR);
            tlr_q        <= (state_d == TAP_TLR);
        end
    end

    assign state_o      = state_q;
    assign shift_ir_o   = shift_ir_q;
    assign capture_ir_o = capture_ir_q;
    assign update_ir_o  = update_ir_q;
    assign shift_dr_o   = shift_dr_q;
    assign capture_dr_o = capture_dr_q;
    assign update_dr_o  = update_dr_q;
    assign tlr_o        = tlr_q;

endmodule

// File: rtl/jtag_bs_wrapper.sv
// Boundary-scan wrapper: TAP, IR, bypass, IDCODE and a {inputs, outputs} BSR
// placed between the chip pins and the core.
module jtag_bs_wrapper
    import jtag_bs_wrapper_pkg::*;
#(
    parameter int          IN_WIDTH   = 16,
    parameter int          OUT_WIDTH  = 4,
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic                 TCLK,
    input  logic                 RstBar,
    input  logic                 TMS,
    input  logic                 TDI,
    output logic                 TDO,
    output logic                 TDO_En,
    input  logic [IN_WIDTH-1:0]  In_Pin,
    output logic [IN_WIDTH-1:0]  Core_In,
    input  logic [OUT_WIDTH-1:0] Core_Out,
    output logic [OUT_WIDTH-1:0] Out_Pin
);

    localparam int BSR_W = IN_WIDTH + OUT_WIDTH;
    localparam logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(OPC_EXTEST);
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(OPC_SAMPLE);
    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(OPC_IDCODE);
    localparam logic [IR_WIDTH-1:0] OP_INTEST = IR_WIDTH'(OPC_INTEST);
    localparam logic [IR_WIDTH-1:0] OP_BYPASS = IR_WIDTH'(op_bypass(IR_WIDTH));
    localparam logic [IR_WIDTH-1:0] IR_CAP    = IR_WIDTH'(IR_CAPTURE);

    tap_state_e tap_state;
    logic shift_ir, capture_ir, update_ir, shift_dr, capture_dr, update_dr, tlr;

    jtag_bs_wrapper_tap_fsm u_tap_fsm (
        .tclk_i       (TCLK),
        .rst_n_i      (RstBar),
        .tms_i        (TMS),
        .state_o      (tap_state),
        .shift_ir_o   (shift_ir),
        .capture_ir_o (capture_ir),
        .update_ir_o  (update_ir),
        .shift_dr_o   (shift_dr),
        .capture_dr_o (capture_dr),
        .update_dr_o  (update_dr),
        .tlr_o        (tlr)
    );

    // Rising-edge shift path
    logic [IR_WIDTH-1:0] ir_sr_q,  ir_sr_d;
    logic [BSR_W-1:0]    bsr_sr_q, bsr_sr_d;
    logic [31:0]         id_sr_q,  id_sr_d;
    logic                byp_q,    byp_d;
    // Falling-edge update path
    logic [IR_WIDTH-1:0] ir_q,     ir_d;
    logic [BSR_W-1:0]    lat_q,    lat_d;
    logic                tdo_q,    tdo_d;
    logic                tdo_en_q, tdo_en_d;

    dr_sel_e dr_sel;
    logic    dr_lsb;
    logic    boundary_mode;

    // Unknown opcodes fall through to bypass, including the explicit all-ones code.
    always_comb begin
        dr_sel = DR_BYPASS;
        case (ir_q)
            OP_EXTEST, OP_SAMPLE, OP_INTEST: dr_sel = DR_BSR;
            OP_IDCODE:                       dr_sel = DR_ID;
            OP_BYPASS:                       dr_sel = DR_BYPASS;
            default:                         dr_sel = DR_BYPASS;
        endcase
    end

    always_comb begin
        dr_lsb = byp_q;
        case (dr_sel)
            DR_BSR:  dr_lsb = bsr_sr_q[0];
            DR_ID:   dr_lsb = id_sr_q[0];
            default: dr_lsb = byp_q;
        endcase
    end

    always_comb begin
        ir_sr_d  = ir_sr_q;
        bsr_sr_d = bsr_sr_q;
        id_sr_d  = id_sr_q;
        byp_d    = byp_q;
        if (capture_ir)
            ir_sr_d = IR_CAP;
        else if (shift_ir)
            ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
        if (capture_dr) begin
            if (dr_sel == DR_BSR)    bsr_sr_d = {In_Pin, Core_Out};
            if (dr_sel == DR_ID)     id_sr_d  = IDCODE_VAL;
            if (dr_sel == DR_BYPASS) byp_d    = 1'b0;
        end else if (shift_dr) begin
            if (dr_sel == DR_BSR)    bsr_sr_d = {TDI, bsr_sr_q[BSR_W-1:1]};
            if (dr_sel == DR_ID)     id_sr_d  = {TDI, id_sr_q[31:1]};
            if (dr_sel == DR_BYPASS) byp_d    = TDI;
        end
    end

    always_ff @(posedge TCLK or negedge RstBar) begin
        if (!RstBar) begin
            ir_sr_q  <= '0;
            bsr_sr_q <= '0;
            id_sr_q  <= '0;
            byp_q    <= 1'b0;
        end else begin
            ir_sr_q  <= ir_sr_d;
            bsr_sr_q <= bsr_sr_d;
            id_sr_q  <= id_sr_d;
            byp_q    <= byp_d;
        end
    end

    // Update latches change only in Update-DR while the BSR is selected, so
    // they survive instruction changes and trips through Test-Logic-Reset.
    always_comb begin
        ir_d     = ir_q;
        lat_d    = lat_q;
        tdo_d    = tdo_q;
        tdo_en_d = (tap_state == TAP_SHIFT_IR) || (tap_state == TAP_SHIFT_DR);
        if (tlr)
            ir_d = OP_IDCODE;
        else if (update_ir)
            ir_d = ir_sr_q;
        if (update_dr && dr_sel == DR_BSR)
            lat_d = bsr_sr_q;
        if (shift_ir)
            tdo_d = ir_sr_q[0];
        else if (shift_dr)
            tdo_d = dr_lsb;
    end

    always_ff @(negedge TCLK or negedge RstBar) begin
        if (!RstBar) begin
            ir_q     <= OP_IDCODE;
            lat_q    <= '0;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            lat_q    <= lat_d;
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign boundary_mode = (ir_q == OP_EXTEST) || (ir_q == OP_INTEST);
    assign Core_In = boundary_mode ? lat_q[BSR_W-1:OUT_WIDTH] : In_Pin;
    assign Out_Pin = boundary_mode ? lat_q[OUT_WIDTH-1:0]     : Core_Out;
    assign TDO     = tdo_q;
    assign TDO_En  = tdo_en_q;

endmodule

// File: tb/tb_jtag_bs_wrapper.sv
// Directed and randomized scan sequences checked against a stream-level model
// of capture, shift-through and update behaviour.
module tb_jtag_bs_wrapper;

  localparam int          IN_W  = 16;
  localparam int          OUT_W = 4;
  localparam int          IR_W  = 4;
  localparam int          BSR_L = IN_W + OUT_W;
  localparam logic [31:0] ID    = 32'h1000_0001;

  logic TCLK = 1'b0;
  logic RstBar;
  logic TMS;
  logic TDI;
  logic TDO;
  logic TDO_En;
  logic [IN_W-1:0]  In_Pin;
  logic [IN_W-1:0]  Core_In;
  logic [OUT_W-1:0] Core_Out;
  logic [OUT_W-1:0] Out_Pin;

  int vectors = 0;
  int miscompares = 0;

  // model state: active instruction and contents of the BSR update latches
  int               ir_m;
  logic [BSR_L-1:0] lat_m;

  jtag_bs_wrapper #(
    .IN_WIDTH   (IN_W),
    .OUT_WIDTH  (OUT_W),
    .IR_WIDTH   (IR_W),
    .IDCODE_VAL (ID)
  ) dut (
    .TCLK     (TCLK),
    .RstBar   (RstBar),
    .TMS      (TMS),
    .TDI      (TDI),
    .TDO      (TDO),
    .TDO_En   (TDO_En),
    .In_Pin   (In_Pin),
    .Core_In  (Core_In),
    .Core_Out (Core_Out),
    .Out_Pin  (Out_Pin)
  );

  // clock / reset
  always #10 TCLK = ~TCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: a register of length len that captured cap, then had n
  // bits shifted through it LSB-first
  function automatic logic [63:0] stream_out(input logic [63:0] cap, input int len,
                                             input logic [63:0] din, input int n);
    logic [63:0] r = '0;
    for (int k = 0; k < n; k++) begin
      if (k < len) r[k] = cap[k];
      else         r[k] = din[k-len];
    end
    return r;
  endfunction

  function automatic logic [63:0] reg_after(input logic [63:0] cap, input int len,
                                            input logic [63:0] din, input int n);
    logic [63:0] r = '0;
    for (int j = 0; j < len; j++) begin
      if (j + n < len) r[j] = cap[j+n];
      else             r[j] = din[j+n-len];
    end
    return r;
  endfunction

  function automatic bit is_bsr(input int op);
    return (op == 0) || (op == 1) || (op == 3);
  endfunction

  function automatic int dr_len(input int op);
    if (is_bsr(op)) return BSR_L;
    if (op == 2)    return 32;
    return 1;
  endfunction

  function automatic logic [63:0] dr_cap(input int op);
    if (is_bsr(op)) return 64'({In_Pin, Core_Out});
    if (op == 2)    return 64'(ID);
    return 64'h0;
  endfunction

  // driver tasks
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCLK);
    @(negedge TCLK);
    #1;
  endtask

  task automatic check_pins(input string tag);
    if (ir_m == 0 || ir_m == 3) begin
      chk({tag, "_core_in"}, 64'(Core_In), 64'(lat_m[BSR_L-1:OUT_W]));
      chk({tag, "_out_pin"}, 64'(Out_Pin), 64'(lat_m[OUT_W-1:0]));
    end else begin
      chk({tag, "_core_in"}, 64'(Core_In), 64'(In_Pin));
      chk({tag, "_out_pin"}, 64'(Out_Pin), 64'(Core_Out));
    end
  endtask

  // shift n bits from RTI, collect TDO, then stop in the update state
  task automatic scan(input bit is_ir, input logic [63:0] din, input int n,
                      output logic [63:0] dout, output logic en_all);
    step(1'b1, 1'b0);
    if (is_ir) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    dout    = '0;
    dout[0] = TDO;
    en_all  = TDO_En;
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i]);
      if (i < n - 1) begin
        dout[i+1] = TDO;
        en_all    = en_all & TDO_En;
      end
    end
    chk(is_ir ? "ir_en_exit" : "dr_en_exit", 64'(TDO_En), 64'h0);
    step(1'b1, 1'b0);
  endtask

  task automatic do_ir(input string tag, input logic [63:0] din, input int n);
    logic [63:0] dout, exp, nxt;
    logic        en;
    exp = stream_out(64'h1, IR_W, din, n);
    nxt = reg_after(64'h1, IR_W, din, n);
    scan(1'b1, din, n, dout, en);
    chk({tag, "_tdo"}, dout, exp);
    chk({tag, "_en"}, 64'(en), 64'h1);
    ir_m = int'(nxt[IR_W-1:0]);
    check_pins({tag, "_upd"});
    step(1'b0, 1'b0);
  endtask

  task automatic do_dr(input string tag, input logic [63:0] din, input int n);
    logic [63:0] dout, cap, exp, nxt;
    logic        en;
    int          len;
    len = dr_len(ir_m);
    cap = dr_cap(ir_m);
    exp = stream_out(cap, len, din, n);
    nxt = reg_after(cap, len, din, n);
    scan(1'b0, din, n, dout, en);
    chk({tag, "_tdo"}, dout, exp);
    chk({tag, "_en"}, 64'(en), 64'h1);
    if (is_bsr(ir_m)) lat_m = nxt[BSR_L-1:0];
    check_pins({tag, "_upd"});
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] din, cap, nxt;
    int          op, n;

    RstBar   = 1'b0;
    TMS      = 1'b1;
    TDI      = 1'b0;
    In_Pin   = 16'($urandom);
    Core_Out = 4'($urandom);
    ir_m     = 2;
    lat_m    = '0;
    #25;
    chk("rst_tdo", 64'(TDO), 64'h0);
    chk("rst_tdo_en", 64'(TDO_En), 64'h0);
    check_pins("rst");
    @(negedge TCLK);
    #1;
    RstBar = 1'b1;
    step(1'b0, 1'b0);

    // IDCODE after reset
    do_dr("idcode", {32'h0, $urandom}, 32);

    // BYPASS
    do_ir("ir_bypass", 64'hF, 4);
    In_Pin = 16'hA5A5;
    #1;
    check_pins("bypass_pins");
    do_dr("bypass", 64'b1101, 4);

    // SAMPLE/PRELOAD
    In_Pin   = 16'h1234;
    Core_Out = 4'h9;
    do_ir("ir_sample", 64'h1, 4);
    do_dr("sample", 64'h00006, BSR_L);
    Core_Out = 4'($urandom);
    #1;
    check_pins("preload_pins");

    // EXTEST
    do_ir("ir_extest", 64'h0, 4);
    chk("extest_out6", 64'(Out_Pin), 64'h6);
    In_Pin   = 16'hBEEF;
    Core_Out = 4'($urandom);
    do_dr("extest", 64'($urandom), BSR_L);

    // INTEST
    do_ir("ir_intest", 64'h3, 4);
    Core_Out = 4'h3;
    do_dr("intest", 64'h00FFA, BSR_L);
    In_Pin = 16'($urandom);
    #1;
    chk("intest_core_in", 64'(Core_In), 64'h00FF);

    // five TMS=1 from Shift-DR in EXTEST; the path passes Update-DR
    do_ir("ir_extest2", 64'h0, 4);
    cap = 64'({In_Pin, Core_Out});
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    nxt   = reg_after(cap, BSR_L, 64'h0, 1);
    lat_m = nxt[BSR_L-1:0];
    ir_m  = 2;
    chk("tlr_tdo_en", 64'(TDO_En), 64'h0);
    check_pins("tlr");
    step(1'b0, 1'b0);
    do_dr("tlr_idcode", {$urandom, $urandom}, 32);

    // reset pulsed in the middle of Shift-IR
    do_ir("ir_extest3", 64'h0, 4);
    do_dr("preset", 64'hFFFFF, BSR_L);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("midshift_tdo", 64'(TDO), 64'h1);
    RstBar = 1'b0;
    #2;
    ir_m  = 2;
    lat_m = '0;
    chk("midrst_tdo", 64'(TDO), 64'h0);
    chk("midrst_tdo_en", 64'(TDO_En), 64'h0);
    check_pins("midrst");
    #2;
    RstBar = 1'b1;
    step(1'b0, 1'b0);
    do_ir("ir_after_rst", 64'h0, 4);

    // randomized instructions, IR lengths and DR shift lengths
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 6))
        0: op = 0;
        1: op = 1;
        2: op = 2;
        3: op = 3;
        4: op = 15;
        default: op = int'($urandom_range(4, 14));
      endcase
      n   = int'($urandom_range(4, 8));
      din = (64'(op) << (n - 4)) | (64'($urandom) & ((64'h1 << (n - 4)) - 64'h1));
      In_Pin   = 16'($urandom);
      Core_Out = 4'($urandom);
      do_ir("rnd_ir", din, n);
      In_Pin   = 16'($urandom);
      Core_Out = 4'($urandom);
      do_dr("rnd_dr", {$urandom, $urandom}, int'($urandom_range(1, 40)));
      In_Pin   = 16'($urandom);
      Core_Out = 4'($urandom);
      #1;
      check_pins("rnd_pins");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jtag_bs_wrapper.md
Name: jtag_bs_wrapper

Overview:
Parametrised boundary-scan wrapper. It places an IEEE 1149.1-style TAP, an instruction register, a bypass register, an IDCODE register and a boundary-scan register around a core with IN_WIDTH inputs and OUT_WIDTH outputs. It is the successor to the fixed 20-cell, EXTEST-only wrapper and adds SAMPLE/PRELOAD, INTEST, IDCODE, widths set by parameter, and a TDO output enable. It sits between the chip pins and the core.

Parameters:
IN_WIDTH, 16, number of input boundary cells (pin to core).
OUT_WIDTH, 4, number of output boundary cells (core to pin).
IR_WIDTH, 4, instruction register length; minimum 2.
IDCODE_VAL, 32'h1000_0001, device ID; bit 0 must be 1.

Ports:
TCLK  input  1  test clock; the only clock.
RstBar  input  1  asynchronous active-low reset (TRST* equivalent).
TMS  input  1  test mode select, sampled on rising TCLK.
TDI  input  1  test data in, sampled on rising TCLK.
TDO  output  1  test data out, updated on falling TCLK.
TDO_En  output  1  high only while the TAP is in Shift-IR or Shift-DR (registered on falling TCLK).
In_Pin  input  IN_WIDTH  chip input pins.
Core_In  output  IN_WIDTH  inputs to the core.
Core_Out  input  OUT_WIDTH  outputs from the core.
Out_Pin  output  OUT_WIDTH  chip output pins.

Behaviour:
- RstBar low, asynchronously:
  - TAP goes to Test-Logic-Reset (TLR).
  - IR shift register = 0; IR update register = IDCODE opcode.
  - BSR shift register and update latches = 0; bypass = 0; IDCODE shift = 0.
  - TDO = 0; TDO_En = 0.
- TAP: the full 16-state IEEE FSM, advanced on rising TCLK by TMS.
  - Five consecutive TMS=1 reach TLR from any state.
  - Entering TLR also loads the IDCODE opcode into the IR update register.
- Opcodes (low IR_WIDTH bits):
  - EXTEST = 0..00
  - SAMPLE_PRELOAD = 0..01
  - IDCODE = 0..10
  - INTEST = 0..11
  - BYPASS = all ones
  - Any other code decodes as BYPASS.
- IR:
  - Capture-IR loads 0..01.
  - Shift-IR shifts right: TDI enters the MSB, the LSB drives the TDO path.
  - Update-IR copies the shift register to the update register on falling TCLK.
- DR selection by current instruction:
  - EXTEST, SAMPLE_PRELOAD, INTEST: BSR.
  - IDCODE: 32-bit ID register.
  - Otherwise: 1-bit bypass.
- BSR, length IN_WIDTH+OUT_WIDTH, ordered {input cells, output cells}:
  - Output cell 0 is nearest TDO; TDI enters input cell IN_WIDTH-1.
  - Capture-DR loads {In_Pin, Core_Out}.
  - Shift-DR shifts right, one bit per rising TCLK.
  - Update-DR copies the shift register to the update latches on falling TCLK.
  - Latches hold their value in every other state and across instruction changes.
- ID register: Capture-DR loads IDCODE_VAL; Shift-DR shifts right with TDI entering bit 31.
- Bypass: Capture-DR loads 0; Shift-DR loads TDI.
- Pin muxing:
  - EXTEST: Out_Pin = output latches; Core_In = input latches.
  - INTEST: Out_Pin = output latches; Core_In = input latches.
  - All other instructions: Out_Pin = Core_Out and Core_In = In_Pin (transparent).
  - The mode change follows the IR update register on the same falling edge.
- TDO:
  - On falling TCLK, TDO takes the LSB of the selected register: IR in Shift-IR, DR in Shift-DR.
  - Outside shift states TDO holds its last value and TDO_En = 0.
- Shift length is unbounded. Shifting beyond the register length passes TDI through with a delay equal to the register length.
- Update with no preceding shift rewrites the captured values.
- RstBar low mid-shift aborts the shift; the update latches are cleared to 0 and the pins become transparent.

Decomposition:
- Shared package:
  - TAP state enum with 4-bit IEEE encoding.
  - Opcode constants as functions of IR_WIDTH.
  - IR capture constant.
- Sub-module tap_fsm: TMS/state logic plus decoded ShiftIR, CaptureIR, UpdateIR, ShiftDR, CaptureDR, UpdateDR and TLR strobes.
- Registers, decode and muxing stay in jtag_bs_wrapper.

Test Plan:
- Reset then RstBar high with TMS=0: Shift-DR reads 32 bits LSB-first = 0x10000001; TDO_En = 1 only during those 32 bits.
- Load IR=1111, enter Shift-DR, shift TDI pattern 1,0,1,1: TDO returns 0 (captured), then 1,0,1 one bit late. Pins stay transparent: In_Pin = 0xA5A5 gives Core_In = 0xA5A5.
- SAMPLE_PRELOAD with In_Pin = 0x1234, Core_Out = 0x9: the first 20 TDO bits are 0x1234_9 LSB-first. Preload 0x0000_6 then Update-DR: Out_Pin stays equal to Core_Out.
- Then EXTEST: Out_Pin = 0x6 right after the Update-IR falling edge. Capture-DR with In_Pin = 0xBEEF shifts out input cells = 0xBEEF.
- INTEST, shift and update input latches = 0x00FF: Core_In = 0x00FF regardless of In_Pin. Core_Out = 0x3 is captured into output cells = 0x3.
- Five TMS=1 from Shift-DR in EXTEST: TLR reached, IR = IDCODE opcode, pins transparent. Separately, RstBar pulsed mid-Shift-IR gives TDO = 0 and latches = 0.
